// File: rtl/vote_tally_if.sv
// Bus between the evm voting FSM / result display and vote_tally.
// The master drives votes, poll control and the count read-select; the slave returns results.
interface vote_tally_if #(
  parameter int CNT_W = 8
);
  logic             vote_lock;
  logic [1:0]       option;
  logic             poll_close;
  logic             poll_open;
  logic [1:0]       tally_sel;
  logic [CNT_W-1:0] tally_count;
  logic             vote_ack;
  logic             vote_reject;
  logic [1:0]       winner;
  logic             tie;
  logic             result_valid;
  logic             overflow;

  modport master (
    output vote_lock, option, poll_close, poll_open, tally_sel,
    input  tally_count, vote_ack, vote_reject, winner, tie, result_valid, overflow
  );

  modport slave (
    input  vote_lock, option, poll_close, poll_open, tally_sel,
    output tally_count, vote_ack, vote_reject, winner, tie, result_valid, overflow
  );
endinterface

// File: rtl/vote_tally.sv
// Per-candidate vote counter with a sequential winner scan on poll close.
// Define VOTE_TALLY_ABSTAIN_EN to count option-0 votes in a separate abstain counter.
module vote_tally #(
  parameter int NUM_CAND = 3,
  parameter int CNT_W    = 8
) (
  input logic         clk,
  input logic         reset,
  vote_tally_if.slave bus
);
  typedef enum logic [1:0] {ST_OPEN, ST_SCAN, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             vote_lock_q;
  logic [CNT_W-1:0] cnt [1:NUM_CAND];
`ifdef VOTE_TALLY_ABSTAIN_EN
  logic [CNT_W-1:0] abstain_cnt;
`endif
  logic [1:0]       scan_idx;
  logic [CNT_W-1:0] scan_max;
  logic             vote_ack;
  logic             vote_reject;
  logic [1:0]       winner;
  logic             tie;
  logic             result_valid;
  logic             overflow;

  logic             vote_event;
  logic             opt_valid;
  logic [CNT_W-1:0] opt_cnt;
  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] tally_count;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vote_event  = bus.vote_lock & ~vote_lock_q;
    opt_cnt     = '0;
    scan_cnt    = '0;
    tally_count = '0;
    for (int i = 1; i <= NUM_CAND; i++) begin
      if (bus.option == 2'(i))    opt_cnt     = cnt[i];
      if (scan_idx == 2'(i))      scan_cnt    = cnt[i];
      if (bus.tally_sel == 2'(i)) tally_count = cnt[i];
    end
`ifdef VOTE_TALLY_ABSTAIN_EN
    if (bus.option == 2'd0)    opt_cnt     = abstain_cnt;
    if (bus.tally_sel == 2'd0) tally_count = abstain_cnt;
    opt_valid = int'(bus.option) <= NUM_CAND;
`else
    opt_valid = (bus.option != 2'd0) && (int'(bus.option) <= NUM_CAND);
`endif
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_OPEN;
      vote_lock_q  <= 1'b0;
      for (int i = 1; i <= NUM_CAND; i++) cnt[i] <= '0;
`ifdef VOTE_TALLY_ABSTAIN_EN
      abstain_cnt  <= '0;
`endif
      scan_idx     <= 2'd1;
      scan_max     <= '0;
      vote_ack     <= 1'b0;
      vote_reject  <= 1'b0;
      winner       <= 2'd0;
      tie          <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      vote_lock_q <= bus.vote_lock;
      vote_ack    <= 1'b0;
      vote_reject <= 1'b0;
      unique case (state)
        ST_OPEN: begin
          if (vote_event) begin
            if (opt_valid) begin
              vote_ack <= 1'b1;
              // A saturated counter holds its value; the vote is still acknowledged.
              if (opt_cnt == CNT_MAX) overflow <= 1'b1;
              for (int i = 1; i <= NUM_CAND; i++)
                if (bus.option == 2'(i) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
`ifdef VOTE_TALLY_ABSTAIN_EN
              if (bus.option == 2'd0 && abstain_cnt != CNT_MAX)
                abstain_cnt <= abstain_cnt + CNT_W'(1);
`endif
            end else begin
              vote_reject <= 1'b1;
            end
          end
          if (bus.poll_close) begin
            state    <= ST_SCAN;
            scan_idx <= 2'd1;
            scan_max <= '0;
          end
        end
        ST_SCAN: begin
          if (vote_event) vote_reject <= 1'b1;
          // Strictly-greater wins, so on equal counts the lower index is kept.
          if (scan_cnt > scan_max) begin
            scan_max <= scan_cnt;
            winner   <= scan_idx;
            tie      <= 1'b0;
          end else if (scan_cnt == scan_max && scan_cnt != '0) begin
            tie <= 1'b1;
          end
          if (scan_idx == 2'(NUM_CAND)) begin
            state        <= ST_DONE;
            result_valid <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 2'd1;
          end
        end
        ST_DONE: begin
          if (vote_event) vote_reject <= 1'b1;
          if (bus.poll_open) begin
            state        <= ST_OPEN;
            result_valid <= 1'b0;
            winner       <= 2'd0;
            tie          <= 1'b0;
            overflow     <= 1'b0;
            for (int i = 1; i <= NUM_CAND; i++) cnt[i] <= '0;
`ifdef VOTE_TALLY_ABSTAIN_EN
            abstain_cnt <= '0;
`endif
          end
        end
        default: state <= ST_OPEN;
      endcase
    end
  end

  assign bus.tally_count  = tally_count;
  assign bus.vote_ack     = vote_ack;
  assign bus.vote_reject  = vote_reject;
  assign bus.winner       = winner;
  assign bus.tie          = tie;
  assign bus.result_valid = result_valid;
  assign bus.overflow     = overflow;
endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: a default instance (3 candidates, 8-bit counts)
// and a small one (2 candidates, 2-bit counts) for saturation and read-select range.
module tb_vote_tally;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef VOTE_TALLY_ABSTAIN_EN
  localparam logic ABSTAIN = 1'b1;
`else
  localparam logic ABSTAIN = 1'b0;
`endif

  vote_tally_if #(.CNT_W(8)) m ();
  vote_tally_if #(.CNT_W(2)) s ();

  vote_tally #(.NUM_CAND(3), .CNT_W(8)) dut_main (.clk(clk), .reset(reset), .bus(m));
  vote_tally #(.NUM_CAND(2), .CNT_W(2)) dut_small (.clk(clk), .reset(reset), .bus(s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_vote(input logic [1:0] opt, input logic exp_ack);
    @(negedge clk);
    m.option    = opt;
    m.vote_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (m.vote_ack !== exp_ack || m.vote_reject !== !exp_ack) begin
      errors++;
      $display("FAIL vote opt=%0d: ack=%b reject=%b, expected ack=%b reject=%b",
               opt, m.vote_ack, m.vote_reject, exp_ack, !exp_ack);
    end
    m.vote_lock = 1'b0;
  endtask

  task automatic expect_counts(input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_c [1:3];
    exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
    for (int i = 1; i <= 3; i++) begin
      m.tally_sel = 2'(i);
      #1;
      checks++;
      if (m.tally_count !== exp_c[i]) begin
        errors++;
        $display("FAIL count cand %0d: got %0d expected %0d", i, m.tally_count, exp_c[i]);
      end
    end
  endtask

  task automatic close_and_scan(input logic [1:0] exp_winner, input logic exp_tie);
    @(negedge clk);
    m.poll_close = 1'b1;
    @(negedge clk);
    m.poll_close = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m.result_valid !== 1'b0) begin
        errors++;
        $display("FAIL result_valid early after E%0d: got %b expected 0", k, m.result_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (m.result_valid !== 1'b1 || m.winner !== exp_winner || m.tie !== exp_tie) begin
      errors++;
      $display("FAIL scan result: valid=%b winner=%0d tie=%b, expected valid=1 winner=%0d tie=%b",
               m.result_valid, m.winner, m.tie, exp_winner, exp_tie);
    end
  endtask

  task automatic reopen();
    @(negedge clk);
    m.poll_open = 1'b1;
    @(negedge clk);
    m.poll_open = 1'b0;
    checks++;
    if (m.result_valid !== 1'b0 || m.winner !== 2'd0 || m.tie !== 1'b0 || m.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reopen: valid=%b winner=%0d tie=%b ovf=%b, expected all 0",
               m.result_valid, m.winner, m.tie, m.overflow);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m.vote_ack !== 1'b0 || m.vote_reject !== 1'b0 || m.winner !== 2'd0 || m.tie !== 1'b0 ||
        m.result_valid !== 1'b0 || m.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: ack=%b rej=%b win=%0d tie=%b valid=%b ovf=%b, expected all 0",
               m.vote_ack, m.vote_reject, m.winner, m.tie, m.result_valid, m.overflow);
    end
    for (int i = 0; i < 4; i++) begin
      m.tally_sel = 2'(i);
      #1;
      checks++;
      if (m.tally_count !== 8'd0) begin
        errors++;
        $display("FAIL reset read sel %0d: got %0d expected 0", i, m.tally_count);
      end
    end
  endtask

  task automatic test_majority();
    logic [1:0] opts [5];
    opts = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
    foreach (opts[i]) do_vote(opts[i], 1'b1);
    expect_counts(8'd1, 8'd3, 8'd1);
    close_and_scan(2'd2, 1'b0);
  endtask

  task automatic test_reopen_collision();
    @(negedge clk);
    m.option    = 2'd1;
    m.vote_lock = 1'b1;
    m.poll_open = 1'b1;
    @(negedge clk);
    m.poll_open = 1'b0;
    checks++;
    if (m.vote_reject !== 1'b1 || m.vote_ack !== 1'b0 || m.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL vote+open: rej=%b ack=%b valid=%b, expected rej=1 ack=0 valid=0",
               m.vote_reject, m.vote_ack, m.result_valid);
    end
    @(negedge clk);
    checks++;
    if (m.vote_ack !== 1'b0) begin
      errors++;
      $display("FAIL held level recounted after open: ack=%b expected 0", m.vote_ack);
    end
    m.vote_lock = 1'b0;
    expect_counts(8'd0, 8'd0, 8'd0);
    do_vote(2'd1, 1'b1);
    expect_counts(8'd1, 8'd0, 8'd0);
    close_and_scan(2'd1, 1'b0);
    reopen();
  endtask

  task automatic test_tie();
    logic [1:0] opts [4];
    opts = '{2'd1, 2'd3, 2'd1, 2'd3};
    foreach (opts[i]) do_vote(opts[i], 1'b1);
    expect_counts(8'd2, 8'd0, 8'd2);
    close_and_scan(2'd1, 1'b1);
    reopen();
  endtask

  task automatic test_held_and_abstain();
    int acks;
    acks = 0;
    @(negedge clk);
    m.option    = 2'd1;
    m.vote_lock = 1'b1;
    repeat (5) begin
      @(negedge clk);
      acks += int'(m.vote_ack);
    end
    m.vote_lock = 1'b0;
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL held vote_lock acks: got %0d expected 1", acks);
    end
    expect_counts(8'd1, 8'd0, 8'd0);
    do_vote(2'd0, ABSTAIN);
    m.tally_sel = 2'd0;
    #1;
    checks++;
    if (m.tally_count !== {7'd0, ABSTAIN}) begin
      errors++;
      $display("FAIL abstain read: got %0d expected %0d", m.tally_count, ABSTAIN);
    end
    close_and_scan(2'd1, 1'b0);
    reopen();
  endtask

  task automatic test_all_zero();
    close_and_scan(2'd0, 1'b0);
    reopen();
  endtask

  task automatic test_saturate_small();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s.option    = 2'd2;
      s.vote_lock = 1'b1;
      @(negedge clk);
      s.vote_lock = 1'b0;
      checks++;
      if (s.vote_ack !== 1'b1) begin
        errors++;
        $display("FAIL small vote %0d ack: got %b expected 1", i, s.vote_ack);
      end
    end
    s.tally_sel = 2'd2;
    #1;
    checks++;
    if (s.tally_count !== 2'd3 || s.overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturation: count=%0d ovf=%b, expected count=3 ovf=1", s.tally_count, s.overflow);
    end
    @(negedge clk);
    s.option    = 2'd3;
    s.vote_lock = 1'b1;
    @(negedge clk);
    s.vote_lock = 1'b0;
    s.tally_sel = 2'd3;
    #1;
    checks++;
    if (s.vote_reject !== 1'b1 || s.tally_count !== 2'd0) begin
      errors++;
      $display("FAIL out-of-range option: rej=%b sel3 read=%0d, expected rej=1 read=0",
               s.vote_reject, s.tally_count);
    end
    @(negedge clk);
    s.poll_close = 1'b1;
    @(negedge clk);
    s.poll_close = 1'b0;
    s.option     = 2'd1;
    s.vote_lock  = 1'b1;
    @(negedge clk);
    s.vote_lock  = 1'b0;
    s.tally_sel  = 2'd1;
    #1;
    checks++;
    if (s.vote_reject !== 1'b1 || s.vote_ack !== 1'b0 || s.tally_count !== 2'd0) begin
      errors++;
      $display("FAIL vote during scan: rej=%b ack=%b cand1=%0d, expected rej=1 ack=0 cand1=0",
               s.vote_reject, s.vote_ack, s.tally_count);
    end
    @(negedge clk);
    checks++;
    if (s.result_valid !== 1'b1 || s.winner !== 2'd2 || s.tie !== 1'b0) begin
      errors++;
      $display("FAIL small scan: valid=%b winner=%0d tie=%b, expected valid=1 winner=2 tie=0",
               s.result_valid, s.winner, s.tie);
    end
    @(negedge clk);
    s.poll_open = 1'b1;
    @(negedge clk);
    s.poll_open = 1'b0;
    s.tally_sel = 2'd2;
    #1;
    checks++;
    if (s.overflow !== 1'b0 || s.tally_count !== 2'd0 || s.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL small reopen: ovf=%b count=%0d valid=%b, expected all 0",
               s.overflow, s.tally_count, s.result_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_vote(2'd2, 1'b1);
    do_vote(2'd2, 1'b1);
    @(negedge clk);
    m.poll_close = 1'b1;
    @(negedge clk);
    m.poll_close = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m.winner !== 2'd2) begin
      errors++;
      $display("FAIL mid-scan winner: got %0d expected 2", m.winner);
    end
    #2 reset = 1'b0;
    m.tally_sel = 2'd2;
    #1;
    checks++;
    if (m.winner !== 2'd0 || m.tie !== 1'b0 || m.result_valid !== 1'b0 || m.overflow !== 1'b0 ||
        m.tally_count !== 8'd0) begin
      errors++;
      $display("FAIL async reset: win=%0d tie=%b valid=%b ovf=%b cand2=%0d, expected all 0",
               m.winner, m.tie, m.result_valid, m.overflow, m.tally_count);
    end
    @(negedge clk);
    reset = 1'b1;
    do_vote(2'd2, 1'b1);
    expect_counts(8'd0, 8'd1, 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    m.vote_lock = 1'b0; m.option = 2'd0; m.poll_close = 1'b0; m.poll_open = 1'b0; m.tally_sel = 2'd0;
    s.vote_lock = 1'b0; s.option = 2'd0; s.poll_close = 1'b0; s.poll_open = 1'b0; s.tally_sel = 2'd0;
    test_reset();
    test_majority();
    test_reopen_collision();
    test_tie();
    test_held_and_abstain();
    test_all_zero();
    test_saturate_small();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
